// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: constants, state codes,
// the buffered-word record and an address alignment helper.
package fetch_stage_pkg;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Fetch FSM encoding
   localparam logic [1:0] ST_REQ  = 2'd0;  // request valid on the bus
   localparam logic [1:0] ST_WAIT = 2'd1;  // one request outstanding
   localparam logic [1:0] ST_DROP = 2'd2;  // outstanding response will be discarded
   localparam logic [1:0] ST_HOLD = 2'd3;  // skid buffer full, decode stalled

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fetch_word_t;

   // Redirect targets are word addresses: the two low bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module fetch_skid_buf
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  fetch_word_t load_word,
   output logic        buf_valid,
   output fetch_word_t buf_word
);

   logic        valid_q, valid_d;
   fetch_word_t word_q, word_d;

   // Next-state: clear beats load, load beats drain.
   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         word_d  = load_word;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   // Buffer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign buf_valid = valid_q;
   assign buf_word  = word_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding memory request FSM,
// redirect handling, skid buffering under stall and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hazard,
   input  logic              flush,
   input  logic              branch,
   input  logic              jump,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       jump_target,
   fetch_stage_if.master     imem,
   output logic [31:0]       IF_ID_instr,
   output logic [31:0]       IF_ID_pc4,
   output logic              IF_ID_valid
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;          // address of the granted request
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic [31:0] if_id_pc4_q, if_id_pc4_d;
   logic        if_id_valid_q, if_id_valid_d;

   logic        redir;
   logic [31:0] redir_target;
   logic        resp_fire;
   fetch_word_t resp_word;
   logic        skid_load, skid_drain, skid_clear;
   logic        skid_valid;
   fetch_word_t skid_word;

   // Redirect decode, response qualification and bus outputs.
   always_comb begin
      redir         = flush | branch | jump;
      redir_target  = word_align(jump ? jump_target : branch_target);
      resp_fire     = (state_q == ST_WAIT) && imem.rvalid;
      resp_word     = '{instr: imem.rdata, pc4: addr_q + 32'd4};
      // A redirect withdraws the request so the old pc can never be granted.
      imem.req      = !reset && (state_q == ST_REQ) && !redir;
      imem.addr     = pc_q;
   end

   // FSM, PC and granted-address next-state.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_clear = 1'b0;
      case (state_q)
         ST_REQ: begin
            if (!redir && imem.gnt) begin
               addr_d  = pc_q;
               pc_d    = pc_q + 32'd4;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redir) begin
               state_d = imem.rvalid ? ST_REQ : ST_DROP;
            end else if (imem.rvalid) begin
               if (hazard) begin
                  skid_load = 1'b1;
                  state_d   = ST_HOLD;
               end else begin
                  state_d   = ST_REQ;
               end
            end
         end
         ST_DROP: begin
            if (imem.rvalid) begin
               state_d = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (redir) begin
               skid_clear = 1'b1;
               state_d    = ST_REQ;
            end else if (!hazard) begin
               skid_drain = 1'b1;
               state_d    = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase
      if (redir) begin
         pc_d = redir_target;
      end
   end

   // IF/ID next-state: redirect bubble, stall hold, buffer, response, bubble.
   always_comb begin
      if_id_instr_d = if_id_instr_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_valid_d = if_id_valid_q;
      if (redir) begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP;
      end else if (hazard) begin
         if_id_valid_d = if_id_valid_q;
      end else if (skid_valid) begin
         if_id_valid_d = 1'b1;
         if_id_instr_d = skid_word.instr;
         if_id_pc4_d   = skid_word.pc4;
      end else if (resp_fire) begin
         if_id_valid_d = 1'b1;
         if_id_instr_d = resp_word.instr;
         if_id_pc4_d   = resp_word.pc4;
      end else begin
         if_id_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any response still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_PC;
         addr_q        <= RESET_PC;
         if_id_instr_q <= NOP;
         if_id_pc4_q   <= 32'h0;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         addr_q        <= addr_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .drain     (skid_drain),
      .clear     (skid_clear),
      .load_word (resp_word),
      .buf_valid (skid_valid),
      .buf_word  (skid_word)
   );

   assign IF_ID_instr = if_id_instr_q;
   assign IF_ID_pc4   = if_id_pc4_q;
   assign IF_ID_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against an in-order instruction-stream model.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        hazard, flush, branch, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] IF_ID_instr, IF_ID_pc4;
   logic        IF_ID_valid;

   int total = 0;
   int bad   = 0;

   fetch_stage_if imem ();

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .hazard        (hazard),
      .flush         (flush),
      .branch        (branch),
      .jump          (jump),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .imem          (imem),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_pc4     (IF_ID_pc4),
      .IF_ID_valid   (IF_ID_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents as a function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hazard = 0; flush = 0; branch = 0; jump = 0;
      branch_target = 0; jump_target = 0;
      imem.gnt = 0; imem.rvalid = 0; imem.rdata = 0;
   endtask

   // Leaves the bench one step after a clock edge with reset just released.
   task automatic do_reset();
      clear_inputs();
      reset = 1;
      next_cycle();
      next_cycle();
      reset = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      next_cycle();
      next_cycle();
      #1;
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", imem.req); end
      total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", IF_ID_valid); end
      total++; if (IF_ID_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 00000000", IF_ID_instr); end
      total++; if (IF_ID_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h want 00000000", IF_ID_pc4); end
      reset = 0;
      #1;
      total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL first_req: got %0b want 1", imem.req); end
      total++; if (imem.addr !== RESET_PC) begin bad++; $display("FAIL first_addr: got %h want %h", imem.addr, RESET_PC); end
      $display("test_reset done: total=%0d", total);
   endtask

   task automatic test_fetch();
      do_reset();
      imem.gnt = 1;
      #1;
      total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL fetch_addr0: got %h want 00000000", imem.addr); end
      next_cycle();
      imem.gnt = 0; imem.rvalid = 1; imem.rdata = 32'h2008_0005;
      #1;
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL fetch_req_wait: got %0b want 0", imem.req); end
      next_cycle();
      imem.rvalid = 0;
      #1;
      total++; if (IF_ID_instr !== 32'h2008_0005) begin bad++; $display("FAIL fetch_instr: got %h want 20080005", IF_ID_instr); end
      total++; if (IF_ID_pc4 !== 32'h4) begin bad++; $display("FAIL fetch_pc4: got %h want 00000004", IF_ID_pc4); end
      total++; if (IF_ID_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid: got %0b want 1", IF_ID_valid); end
      total++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin bad++; $display("FAIL fetch_addr4: got req=%0b addr=%h want req=1 addr=00000004", imem.req, imem.addr); end
      $display("test_fetch done: total=%0d", total);
   endtask

   task automatic test_stall();
      do_reset();
      imem.gnt = 1;
      next_cycle();
      imem.gnt = 0; hazard = 1; imem.rvalid = 1; imem.rdata = 32'hAAAA_0001;
      next_cycle();
      imem.rvalid = 0;
      #1;
      total++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== 32'h0) begin bad++; $display("FAIL stall_hold: got valid=%0b instr=%h want valid=0 instr=00000000", IF_ID_valid, IF_ID_instr); end
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL stall_req1: got %0b want 0", imem.req); end
      next_cycle();
      #1;
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL stall_req2: got %0b want 0", imem.req); end
      hazard = 0;
      next_cycle();
      #1;
      total++; if (IF_ID_instr !== 32'hAAAA_0001 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL stall_drain: got instr=%h valid=%0b want instr=aaaa0001 valid=1", IF_ID_instr, IF_ID_valid); end
      total++; if (IF_ID_pc4 !== 32'h4) begin bad++; $display("FAIL stall_pc4: got %h want 00000004", IF_ID_pc4); end
      total++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin bad++; $display("FAIL stall_resume: got req=%0b addr=%h want req=1 addr=00000004", imem.req, imem.addr); end
      $display("test_stall done: total=%0d", total);
   endtask

   task automatic test_jump_wait();
      do_reset();
      imem.gnt = 1;
      next_cycle();
      imem.gnt = 0; flush = 1; jump = 1; jump_target = 32'h0000_0040;
      next_cycle();
      flush = 0; jump = 0;
      #1;
      total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL jump_valid: got %0b want 0", IF_ID_valid); end
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL jump_drop_req: got %0b want 0", imem.req); end
      next_cycle();
      imem.rvalid = 1; imem.rdata = 32'hDEAD_BEEF;
      next_cycle();
      imem.rvalid = 0;
      #1;
      total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL jump_discard: got valid=%0b instr=%h want valid=0", IF_ID_valid, IF_ID_instr); end
      total++; if (imem.req !== 1'b1 || imem.addr !== 32'h40) begin bad++; $display("FAIL jump_addr: got req=%0b addr=%h want req=1 addr=00000040", imem.req, imem.addr); end
      $display("test_jump_wait done: total=%0d", total);
   endtask

   task automatic test_branch_jump();
      do_reset();
      imem.gnt = 1; flush = 1; branch = 1; jump = 1;
      branch_target = 32'h0000_0100; jump_target = 32'h0000_0203;
      #1;
      total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL bj_req_drop: got %0b want 0", imem.req); end
      next_cycle();
      clear_inputs();
      #1;
      total++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin bad++; $display("FAIL bj_addr: got req=%0b addr=%h want req=1 addr=00000200", imem.req, imem.addr); end
      $display("test_branch_jump done: total=%0d", total);
   endtask

   task automatic test_wrap();
      do_reset();
      flush = 1; jump = 1; jump_target = 32'hFFFF_FFFC;
      next_cycle();
      clear_inputs();
      imem.gnt = 1;
      #1;
      total++; if (imem.addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem.addr); end
      next_cycle();
      imem.gnt = 0; imem.rvalid = 1; imem.rdata = 32'h1234_5678;
      next_cycle();
      imem.rvalid = 0;
      #1;
      total++; if (IF_ID_pc4 !== 32'h0 || IF_ID_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc4: got pc4=%h valid=%0b want pc4=00000000 valid=1", IF_ID_pc4, IF_ID_valid); end
      total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL wrap_next: got %h want 00000000", imem.addr); end
      $display("test_wrap done: total=%0d", total);
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      imem.gnt = 1;
      next_cycle();
      imem.gnt = 0; reset = 1;
      next_cycle();
      reset = 0; imem.rvalid = 1; imem.rdata = 32'hBAD0_0001;
      #1;
      total++; if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin bad++; $display("FAIL rst_wait_req: got req=%0b addr=%h want req=1 addr=%h", imem.req, imem.addr, RESET_PC); end
      next_cycle();
      imem.rvalid = 0;
      #1;
      total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_stray: got valid=%0b instr=%h want valid=0", IF_ID_valid, IF_ID_instr); end
      total++; if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin bad++; $display("FAIL rst_wait_restart: got req=%0b addr=%h want req=1 addr=%h", imem.req, imem.addr, RESET_PC); end
      $display("test_reset_mid_wait done: total=%0d", total);
   endtask

   // Random memory latency, grants, stalls and redirects. Expected behaviour:
   // decode consumes IF/ID when valid and not stalled; consumed words must be
   // the program-order stream from the last redirect target (or reset PC).
   task automatic test_random();
      logic [31:0] exp_pc, paddr, last_addr;
      int          cnt, consumed;
      bit          pending, last_ungranted, last_redir, rd;
      do_reset();
      exp_pc = RESET_PC; paddr = 0; last_addr = 0; cnt = 0; consumed = 0;
      pending = 0; last_ungranted = 0; last_redir = 0;
      for (int c = 0; c < 4000; c++) begin
         imem.rvalid = 0;
         if (pending) begin
            if (cnt == 1) begin
               imem.rvalid = 1; imem.rdata = mem_word(paddr); pending = 0;
            end else begin
               cnt--;
            end
         end
         imem.gnt = ($urandom_range(0, 9) < 7);
         hazard   = ($urandom_range(0, 9) < 3);
         rd       = ($urandom_range(0, 99) < 6);
         flush = rd; branch = 0; jump = 0;
         if (rd) begin
            case ($urandom_range(0, 2))
               0:       branch = 1;
               1:       jump = 1;
               default: begin branch = 1; jump = 1; end
            endcase
            branch_target = $urandom;
            jump_target   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         end
         #1;
         if (last_redir) begin
            total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL rand_redir_bubble: cycle %0d got valid=%0b want 0", c, IF_ID_valid); end
         end
         if (IF_ID_valid && !hazard && !rd) begin
            total++; if (IF_ID_instr !== mem_word(exp_pc) || IF_ID_pc4 !== exp_pc + 32'd4) begin bad++; $display("FAIL rand_stream: cycle %0d got instr=%h pc4=%h want instr=%h pc4=%h", c, IF_ID_instr, IF_ID_pc4, mem_word(exp_pc), exp_pc + 32'd4); end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (rd) exp_pc = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
         if (last_ungranted && imem.req) begin
            total++; if (imem.addr !== last_addr) begin bad++; $display("FAIL rand_addr_stable: cycle %0d got %h want %h", c, imem.addr, last_addr); end
         end
         if (imem.req) begin
            total++; if (pending) begin bad++; $display("FAIL rand_single_outstanding: cycle %0d got req=1 with response pending want req=0", c); end
         end
         if (imem.req && imem.gnt) begin
            pending = 1; paddr = imem.addr; cnt = $urandom_range(1, 3);
         end
         last_ungranted = imem.req && !imem.gnt;
         last_addr      = imem.addr;
         last_redir     = rd;
         next_cycle();
      end
      clear_inputs();
      total++; if (consumed < 100) begin bad++; $display("FAIL rand_progress: got %0d instructions want at least 100", consumed); end
      $display("test_random done: consumed=%0d total=%0d", consumed, total);
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_fetch();
      test_stall();
      test_jump_wait();
      test_branch_jump();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
